// File: rtl/ioctl_rom_loader_if.sv
// ioctl download bus between the HPS ioctl stream and the ROM loader.
//   ioctl_*  : download stream from hps_io (download flag, byte strobe,
//              index, byte address, byte data)
//   dn_*     : registered ROM write port toward the game core ROM
// master : the side driving the ioctl stream and receiving ROM writes
// slave  : the loader
interface ioctl_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr
  );
endinterface

// File: rtl/ioctl_rom_loader.sv
// Download sequencer between hps_io and the Poly-Play core.
// Qualifies ROM bytes into a registered write port, latches the title number,
// holds the game CPU in reset during a ROM download and for HOLD_CYCLES after
// it, and keeps a checksum / byte count of the current ROM load.
// Ports:
//   clk_sys     system clock, rising edge
//   reset       synchronous, active-high
//   bus         ioctl stream in, dn_addr/dn_data/dn_wr ROM write port out
//   tno         latched title number
//   cpu_hold    high while the game core must stay in reset
//   rom_ready   high once a ROM load and its hold window have completed
//   overflow    sticky: a ROM byte beyond MAX_BYTES arrived in this load
//   checksum    mod-2^16 sum of accepted ROM bytes in this load
//   byte_count  number of accepted ROM bytes in this load
//
// state | meaning
// IDLE  | no ROM loaded since reset
// LOAD  | ROM download in progress
// HOLD  | download finished, settling window counting down
// READY | ROM loaded, game core released
module ioctl_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [7:0]  TNO_INDEX   = 8'd1,
  parameter logic [16:0] MAX_BYTES   = 17'd65536,
  parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  ioctl_rom_loader_if.slave        bus,
  output logic [7:0]               tno,
  output logic                     cpu_hold,
  output logic                     rom_ready,
  output logic                     overflow,
  output logic [15:0]              checksum,
  output logic [16:0]              byte_count
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, READY} state_t;

  state_t      state, state_nxt;
  logic [15:0] hold_cnt, hold_cnt_nxt;
  logic        dl_q;
  logic        start, fall, rom_wr, in_range, acc, drop;

  assign start    = bus.ioctl_download & ~dl_q & (bus.ioctl_index == ROM_INDEX);
  assign fall     = ~bus.ioctl_download & dl_q;
  // Only bytes belonging to a load we saw start are taken; after a reset in
  // the middle of a download the rest of that stream is ignored.
  assign rom_wr   = bus.ioctl_download & bus.ioctl_wr & (bus.ioctl_index == ROM_INDEX)
                    & ((state == LOAD) | start);
  assign in_range = bus.ioctl_addr < {8'd0, MAX_BYTES};
  assign acc      = rom_wr & in_range;
  assign drop     = rom_wr & ~in_range;

  // Tracks the download flag through reset as well, so a download still
  // running when reset releases is not mistaken for a fresh start.
  always_ff @(posedge clk_sys) begin
    dl_q <= bus.ioctl_download;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE, READY: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (fall) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = HOLD_CYCLES - 16'd1;
        end
      end
      HOLD: begin
        if (start) begin
          state_nxt = LOAD;
        end else if (hold_cnt == 16'd0) begin
          state_nxt = READY;
        end else begin
          hold_cnt_nxt = hold_cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_hold  = (state != READY);
  assign rom_ready = (state == READY);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.dn_addr <= '0;
      bus.dn_data <= '0;
      bus.dn_wr   <= 1'b0;
      tno         <= '0;
      overflow    <= 1'b0;
      checksum    <= '0;
      byte_count  <= '0;
    end else begin
      bus.dn_wr <= acc;
      if (acc) begin
        bus.dn_addr <= bus.ioctl_addr[15:0];
        bus.dn_data <= bus.ioctl_dout;
      end
      if (bus.ioctl_wr && (bus.ioctl_index == TNO_INDEX)) begin
        tno <= bus.ioctl_dout;
      end
      // A start clears the load status; a byte in the same cycle still counts.
      if (start) begin
        checksum   <= acc ? {8'd0, bus.ioctl_dout} : 16'd0;
        byte_count <= acc ? 17'd1 : 17'd0;
        overflow   <= drop;
      end else begin
        if (acc) begin
          checksum <= checksum + {8'd0, bus.ioctl_dout};
          if (byte_count != 17'h1FFFF) byte_count <= byte_count + 17'd1;
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ioctl_rom_loader.sv
module tb_ioctl_rom_loader;
  localparam int H = 20;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [7:0]  tno;
  logic        cpu_hold, rom_ready, overflow;
  logic [15:0] checksum;
  logic [16:0] byte_count;

  int errors = 0;
  int checks = 0;
  int exp_sum;
  int exp_cnt;

  ioctl_rom_loader_if bus();

  ioctl_rom_loader #(.HOLD_CYCLES(16'(H))) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bus        (bus),
    .tno        (tno),
    .cpu_hold   (cpu_hold),
    .rom_ready  (rom_ready),
    .overflow   (overflow),
    .checksum   (checksum),
    .byte_count (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_add(input logic [7:0] d);
    exp_sum = (exp_sum + int'(d)) % 65536;
    exp_cnt = exp_cnt + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.dn_addr !== 16'd0) begin errors++; $display("FAIL reset_dn_addr got=%h exp=0", bus.dn_addr); end
    checks++; if (bus.dn_data !== 8'd0) begin errors++; $display("FAIL reset_dn_data got=%h exp=0", bus.dn_data); end
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("FAIL reset_dn_wr got=%b exp=0", bus.dn_wr); end
    checks++; if (tno !== 8'd0) begin errors++; $display("FAIL reset_tno got=%h exp=0", tno); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (rom_ready !== 1'b0) begin errors++; $display("FAIL reset_rom_ready got=%b exp=0", rom_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (checksum !== 16'd0) begin errors++; $display("FAIL reset_checksum got=%h exp=0", checksum); end
    checks++; if (byte_count !== 17'd0) begin errors++; $display("FAIL reset_byte_count got=%h exp=0", byte_count); end
  endtask

  // Drops download and counts cycles until rom_ready; must be exactly H+1.
  task automatic finish_download(input string name);
    int n;
    n = 0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL %s_hold_window got=%b exp=1", name, cpu_hold); end
      end
    end while (rom_ready !== 1'b1 && n < 4 * H);
    checks++; if (n !== H + 1) begin errors++; $display("FAIL %s_ready_latency got=%0d exp=%0d", name, n, H + 1); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL %s_cpu_release got=%b exp=0", name, cpu_hold); end
  endtask

  task automatic test_basic_load();
    logic [7:0] vals [3];
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'hFF;
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_in_load got=%b exp=1", cpu_hold); end
    for (int i = 0; i < 3; i++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = vals[i];
      tick();
      checks++;
      if (bus.dn_wr !== 1'b1 || bus.dn_addr !== 16'(i) || bus.dn_data !== vals[i]) begin
        errors++;
        $display("FAIL basic_write%0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", i, bus.dn_wr, bus.dn_addr, bus.dn_data, 16'(i), vals[i]);
      end
    end
    bus.ioctl_wr = 1'b0;
    tick();
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("FAIL basic_single_pulse got=%b exp=0", bus.dn_wr); end
    checks++; if (bus.dn_addr !== 16'd2 || bus.dn_data !== 8'hFF) begin errors++; $display("FAIL basic_hold_last got a=%h d=%h exp a=0002 d=ff", bus.dn_addr, bus.dn_data); end
    checks++; if (checksum !== 16'h0102) begin errors++; $display("FAIL basic_checksum got=%h exp=0102", checksum); end
    checks++; if (byte_count !== 17'd3) begin errors++; $display("FAIL basic_byte_count got=%0d exp=3", byte_count); end
    finish_download("basic");
  endtask

  task automatic test_title();
    logic [7:0] v;
    bus.ioctl_index = 8'd1;
    bus.ioctl_wr = 1'b1;
    bus.ioctl_dout = 8'h05;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++; if (tno !== 8'h05) begin errors++; $display("FAIL title_tno got=%h exp=05", tno); end
    checks++; if (rom_ready !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL title_state got ready=%b hold=%b exp ready=1 hold=0", rom_ready, cpu_hold); end
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom);
      bus.ioctl_download = i[0];
      bus.ioctl_wr = 1'b1;
      bus.ioctl_dout = v;
      tick();
      bus.ioctl_wr = 1'b0;
      checks++; if (tno !== v) begin errors++; $display("FAIL title_rand%0d got=%h exp=%h", i, tno, v); end
    end
    bus.ioctl_download = 1'b0;
    tick();
    checks++; if (rom_ready !== 1'b1) begin errors++; $display("FAIL title_ready_kept got=%b exp=1", rom_ready); end
  endtask

  task automatic test_overflow_random();
    logic        w;
    logic [24:0] a;
    logic [7:0]  d;
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    exp_sum = 0;
    exp_cnt = 0;
    checks++; if (rom_ready !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL ovf_start_state got ready=%b hold=%b exp ready=0 hold=1", rom_ready, cpu_hold); end
    checks++; if (checksum !== 16'd0 || byte_count !== 17'd0) begin errors++; $display("FAIL ovf_start_clear got sum=%h cnt=%0d exp 0 0", checksum, byte_count); end
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = (i == 39) ? 25'h0FFFF : 25'($urandom_range(0, 65535));
      if (i == 39) w = 1'b1;
      d = 8'($urandom);
      bus.ioctl_wr = w;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      if (w) model_add(d);
      tick();
      checks++;
      if (bus.dn_wr !== w || (w && (bus.dn_addr !== a[15:0] || bus.dn_data !== d))) begin
        errors++;
        $display("FAIL ovf_stream%0d got wr=%b a=%h d=%h exp wr=%b a=%h d=%h", i, bus.dn_wr, bus.dn_addr, bus.dn_data, w, a[15:0], d);
      end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got=%b exp=0", overflow); end
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = 25'h10000;
    bus.ioctl_dout = 8'hAA;
    tick();
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("FAIL ovf_no_wr got=%b exp=0", bus.dn_wr); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    bus.ioctl_addr = 25'h1000005;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("FAIL ovf_high_addr_wr got=%b exp=0", bus.dn_wr); end
    checks++; if (checksum !== 16'(exp_sum)) begin errors++; $display("FAIL ovf_checksum got=%h exp=%h", checksum, 16'(exp_sum)); end
    checks++; if (byte_count !== 17'(exp_cnt)) begin errors++; $display("FAIL ovf_byte_count got=%0d exp=%0d", byte_count, exp_cnt); end
    bus.ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (cpu_hold !== 1'b1 || rom_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_hold got hold=%b ready=%b exp 1 0", cpu_hold, rom_ready); end
  endtask

  task automatic test_restart_in_hold();
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    bus.ioctl_wr = 1'b1;
    bus.ioctl_addr = 25'd0;
    bus.ioctl_dout = 8'h7E;
    tick();
    bus.ioctl_wr = 1'b0;
    checks++; if (bus.dn_wr !== 1'b1 || bus.dn_data !== 8'h7E) begin errors++; $display("FAIL restart_wr got wr=%b d=%h exp 1 7e", bus.dn_wr, bus.dn_data); end
    checks++; if (checksum !== 16'h007E || byte_count !== 17'd1) begin errors++; $display("FAIL restart_counts got sum=%h cnt=%0d exp 007e 1", checksum, byte_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL restart_ovf_clear got=%b exp=0", overflow); end
    for (int i = 0; i < H + 5; i++) tick();
    checks++; if (cpu_hold !== 1'b1 || rom_ready !== 1'b0) begin errors++; $display("FAIL restart_in_load got hold=%b ready=%b exp 1 0", cpu_hold, rom_ready); end
    finish_download("restart");
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] d;
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b1;
    tick();
    exp_sum = 0;
    exp_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      d = 8'($urandom);
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = d;
      model_add(d);
      tick();
      checks++;
      if (bus.dn_wr !== 1'b1 || bus.dn_data !== d) begin errors++; $display("FAIL b2b_write%0d got wr=%b d=%h exp 1 %h", i, bus.dn_wr, bus.dn_data, d); end
    end
    checks++; if (checksum !== 16'(exp_sum) || byte_count !== 17'(exp_cnt)) begin errors++; $display("FAIL b2b_counts got sum=%h cnt=%0d exp %h %0d", checksum, byte_count, 16'(exp_sum), exp_cnt); end
    reset = 1'b1;
    bus.ioctl_addr = 25'd100;
    tick();
    reset = 1'b0;
    checks++; if (bus.dn_wr !== 1'b0 || bus.dn_addr !== 16'd0 || bus.dn_data !== 8'd0) begin errors++; $display("FAIL rst_mid_port got wr=%b a=%h d=%h exp 0 0 0", bus.dn_wr, bus.dn_addr, bus.dn_data); end
    checks++; if (checksum !== 16'd0 || byte_count !== 17'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_status got sum=%h cnt=%0d ovf=%b exp 0 0 0", checksum, byte_count, overflow); end
    checks++; if (tno !== 8'd0 || cpu_hold !== 1'b1 || rom_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl got tno=%h hold=%b ready=%b exp 0 1 0", tno, cpu_hold, rom_ready); end
    for (int i = 0; i < 5; i++) begin
      bus.ioctl_addr = 25'(101 + i);
      bus.ioctl_dout = 8'($urandom);
      tick();
      checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("FAIL rst_ignore%0d got=%b exp=0", i, bus.dn_wr); end
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < H + 5; i++) tick();
    checks++; if (byte_count !== 17'd0) begin errors++; $display("FAIL rst_ignore_count got=%0d exp=0", byte_count); end
    checks++; if (rom_ready !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_stays_idle got ready=%b hold=%b exp 0 1", rom_ready, cpu_hold); end
  endtask

  task automatic test_no_download();
    logic w;
    logic [7:0] d;
    bus.ioctl_index = 8'd0;
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'($urandom_range(0, 65535));
      bus.ioctl_dout = 8'($urandom);
      tick();
      checks++; if (bus.dn_wr !== 1'b0) begin errors++; $display("FAIL nodl_wr%0d got=%b exp=0", i, bus.dn_wr); end
    end
    bus.ioctl_wr = 1'b0;
    checks++; if (byte_count !== 17'd0 || checksum !== 16'd0) begin errors++; $display("FAIL nodl_counts got sum=%h cnt=%0d exp 0 0", checksum, byte_count); end
    // Fresh load from IDLE with gapped random writes.
    exp_sum = 0;
    exp_cnt = 0;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom);
      d = 8'($urandom);
      bus.ioctl_wr = w;
      bus.ioctl_addr = 25'(i);
      bus.ioctl_dout = d;
      if (w) model_add(d);
      tick();
      checks++; if (bus.dn_wr !== w) begin errors++; $display("FAIL gap_wr%0d got=%b exp=%b", i, bus.dn_wr, w); end
    end
    bus.ioctl_wr = 1'b0;
    checks++; if (checksum !== 16'(exp_sum) || byte_count !== 17'(exp_cnt)) begin errors++; $display("FAIL gap_counts got sum=%h cnt=%0d exp %h %0d", checksum, byte_count, 16'(exp_sum), exp_cnt); end
    finish_download("gap");
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_title();
    test_overflow_random();
    test_restart_in_hold();
    test_reset_mid_load();
    test_no_download();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ioctl_rom_loader.md
# ioctl_rom_loader

Download sequencer between the HPS `hps_io` ioctl stream and the Poly-Play game core. It qualifies ROM bytes (index 0) into a registered `dn_addr`/`dn_data`/`dn_wr` write port and captures the title number (index 1). It also holds the game CPU in reset during a download and for a fixed settling window afterwards. A running checksum and byte count are kept for verification and OSD/debug readout.

## Interface
Parameters:
- ROM_INDEX, 8'd0, ioctl_index value carrying ROM image bytes
- TNO_INDEX, 8'd1, ioctl_index value carrying the title-number byte
- MAX_BYTES, 17'd65536, number of valid ROM addresses; bytes at ioctl_addr >= MAX_BYTES are dropped
- HOLD_CYCLES, 16'd1024, clk_sys cycles of cpu_hold after download end (must be >= 1)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ioctl_download  in  1  high while an HPS download is in progress
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_index  in  8  download index
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- dn_addr  out  16  registered ROM write address (ioctl_addr[15:0])
- dn_data  out  8  registered ROM write data
- dn_wr  out  1  one-cycle ROM write strobe
- tno  out  8  latched title number
- cpu_hold  out  1  high = game core must be held in reset
- rom_ready  out  1  high after a complete ROM load and hold window
- overflow  out  1  sticky: a ROM byte with address >= MAX_BYTES arrived in the current load
- checksum  out  16  mod-2^16 sum of accepted ROM bytes in the current load
- byte_count  out  17  number of accepted ROM bytes in the current load

## Operation
- Accepted ROM write (acc): ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX) & (ioctl_addr < MAX_BYTES). Address compare is done on the full 25 bits.
- Dropped write: the same condition but with ioctl_addr >= MAX_BYTES. It sets overflow and produces no dn_wr.
- Writes with ioctl_download = 0 are ignored entirely.
- Title write: ioctl_wr & (ioctl_index == TNO_INDEX), with ioctl_download ignored. tno <= ioctl_dout. The last write wins. State, checksum and cpu_hold are not affected.
- ROM load start (start): rising edge of ioctl_download while ioctl_index == ROM_INDEX, detected with a registered copy of ioctl_download.
- On start: checksum, byte_count and overflow clear, and rom_ready drops.
- If acc occurs in the same cycle as start, the clear and the add combine. Result: checksum = ioctl_dout, byte_count = 1.
- checksum: add ioctl_dout zero-extended, wrap mod 2^16.
- byte_count: +1 per acc. It saturates at 17'h1FFFF. This is unreachable with the default MAX_BYTES.
- FSM states:
  - IDLE: reset state.
  - LOAD
  - HOLD
  - READY
- FSM transitions:
  - IDLE or READY -> LOAD on start.
  - LOAD -> HOLD on the falling edge of ioctl_download, loading the hold counter with HOLD_CYCLES-1.
  - HOLD counts down to 0, then -> READY.
  - HOLD -> LOAD on start: the counter is abandoned and the load restarts.
- Downloads on other indices do not change FSM state.
- cpu_hold = 1 in IDLE, LOAD and HOLD; 0 only in READY. rom_ready = (state == READY).
- Overflow does not block READY. It is status only.

## Timing
- Reset values:
  - dn_addr = 0, dn_data = 0, dn_wr = 0, tno = 0
  - cpu_hold = 1, rom_ready = 0, overflow = 0, checksum = 0, byte_count = 0
  - FSM = IDLE
- Reset asserted mid-load aborts the load; all of the above apply on the next edge.
- dn_wr latency: acc at cycle N gives dn_wr = 1 at N+1, with dn_addr/dn_data holding that byte. dn_wr is exactly one cycle per acc.
- dn_addr/dn_data hold their last values when dn_wr = 0.
- Back-to-back acc on consecutive cycles produces consecutive dn_wr pulses, with no drops.
- checksum, byte_count and overflow update at N+1, in step with dn_wr.
- tno updates one cycle after the title write.
- Falling edge of ioctl_download sampled at cycle F: state is HOLD at F+1, and cpu_hold falls / rom_ready rises at F+1+HOLD_CYCLES.
- A final acc coincident with the fall is still written: dn_wr at F+1.

## Test plan
- Reset, then download index 0 with bytes 0x01, 0x02, 0xFF at addresses 0..2 on consecutive cycles:
  - 3 dn_wr pulses, each 1 cycle after its ioctl_wr.
  - checksum = 0x0102, byte_count = 3.
  - rom_ready rises exactly HOLD_CYCLES+1 cycles after download falls.
- Index 1 write of 0x05 during READY: tno = 0x05 next cycle. rom_ready stays 1 and cpu_hold stays 0.
- ROM byte 0xAA at addr 0x10000 (MAX_BYTES = 65536): no dn_wr, overflow = 1, checksum unchanged. The next start clears overflow.
- New index-0 download started during HOLD: state returns to LOAD, cpu_hold stays 1, and counters clear. A byte 0x7E coincident with start gives checksum = 0x007E, byte_count = 1.
- Reset asserted for 1 cycle mid-load after 100 bytes: all outputs at reset values on the next edge; the remaining ioctl_wr pulses are ignored until a new start.
- ioctl_wr on index 0 with ioctl_download = 0: no dn_wr and no counter change.
